// File: rtl/sos_receiver.sv
// sos_receiver: Morse receiver that measures mark/space run lengths on a
// keyed line, classifies marks as dots or dashes, assembles letters and
// flags the letter sequence S-O-S (overlapping detection).
//
// Optional build macro SOS_RX_INPUT_SYNC_EN: when defined, dataIn passes
// through a 2-flop synchronizer (reset to 0) before the line FSM, adding
// two cycles to every output timing. When undefined, dataIn drives the
// line FSM directly for a synchronous connection to the driver.
module sos_receiver #(
  parameter int CNT_W      = 5,
  parameter int DOT_MAX    = 2,
  parameter int DASH_MAX   = 6,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataIn,
  output logic       dotPulse,
  output logic       dashPulse,
  output logic       letterValid,
  output logic [1:0] letterCode,
  output logic       sosDetected,
  output logic       errorFlag
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} line_state_t;
  typedef enum logic [1:0] {SEQ0, SEQ_S, SEQ_SO} seq_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_MAX_C   = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);

  localparam logic [1:0] CODE_OTHER = 2'd0;
  localparam logic [1:0] CODE_S     = 2'd1;
  localparam logic [1:0] CODE_O     = 2'd2;

  logic line_in;

`ifdef SOS_RX_INPUT_SYNC_EN
  logic [1:0] sync_reg;

  // Two-flop synchronizer for an asynchronous keyed line
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], dataIn};
  end

  assign line_in = sync_reg[1];
`else
  assign line_in = dataIn;
`endif

  line_state_t      state_reg, state_next;
  seq_state_t       seq_reg, seq_next;
  logic [CNT_W-1:0] mark_cnt_reg, mark_cnt_next;
  logic [CNT_W-1:0] space_cnt_reg, space_cnt_next;
  logic [2:0]       elem_cnt_reg, elem_cnt_next;
  logic             all_dot_reg, all_dot_next;
  logic             all_dash_reg, all_dash_next;
  logic             dot_reg, dot_next;
  logic             dash_reg, dash_next;
  logic             err_reg, err_next;
  logic             lv_reg, lv_next;
  logic             sos_reg, sos_next;
  logic [1:0]       code_reg, code_next;
  logic [1:0]       code_now;
  logic             space_step;

  // State, counters, letter buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      seq_reg       <= SEQ0;
      mark_cnt_reg  <= '0;
      space_cnt_reg <= '0;
      elem_cnt_reg  <= 3'd0;
      all_dot_reg   <= 1'b1;
      all_dash_reg  <= 1'b1;
      dot_reg       <= 1'b0;
      dash_reg      <= 1'b0;
      err_reg       <= 1'b0;
      lv_reg        <= 1'b0;
      sos_reg       <= 1'b0;
      code_reg      <= CODE_OTHER;
    end else begin
      state_reg     <= state_next;
      seq_reg       <= seq_next;
      mark_cnt_reg  <= mark_cnt_next;
      space_cnt_reg <= space_cnt_next;
      elem_cnt_reg  <= elem_cnt_next;
      all_dot_reg   <= all_dot_next;
      all_dash_reg  <= all_dash_next;
      dot_reg       <= dot_next;
      dash_reg      <= dash_next;
      err_reg       <= err_next;
      lv_reg        <= lv_next;
      sos_reg       <= sos_next;
      code_reg      <= code_next;
    end
  end

  // Line FSM, mark classification, letter assembly and sequence tracking
  always_comb begin
    state_next     = state_reg;
    seq_next       = seq_reg;
    mark_cnt_next  = mark_cnt_reg;
    space_cnt_next = space_cnt_reg;
    elem_cnt_next  = elem_cnt_reg;
    all_dot_next   = all_dot_reg;
    all_dash_next  = all_dash_reg;
    dot_next       = 1'b0;
    dash_next      = 1'b0;
    err_next       = 1'b0;
    lv_next        = 1'b0;
    sos_next       = 1'b0;
    code_next      = code_reg;
    code_now       = CODE_OTHER;
    // A low sample while a mark or space is in progress advances the space count
    space_step     = (state_reg != IDLE) && !line_in;

    case (state_reg)
      IDLE: begin
        if (line_in) begin
          state_next    = MARK;
          mark_cnt_next = CNT_ONE;
        end
      end
      MARK: begin
        if (line_in) begin
          if (mark_cnt_reg != CNT_MAX) mark_cnt_next = mark_cnt_reg + CNT_ONE;
        end else begin
          state_next     = SPACE;
          space_cnt_next = CNT_ONE;
          if (mark_cnt_reg <= DOT_MAX_C) begin
            dot_next      = 1'b1;
            all_dash_next = 1'b0;
            if (elem_cnt_reg != 3'd7) elem_cnt_next = elem_cnt_reg + 3'd1;
          end else if (mark_cnt_reg <= DASH_MAX_C) begin
            dash_next    = 1'b1;
            all_dot_next = 1'b0;
            if (elem_cnt_reg != 3'd7) elem_cnt_next = elem_cnt_reg + 3'd1;
          end else begin
            // Overlong mark: drop the partial letter and restart the sequence
            err_next      = 1'b1;
            elem_cnt_next = 3'd0;
            all_dot_next  = 1'b1;
            all_dash_next = 1'b1;
            seq_next      = SEQ0;
          end
        end
      end
      SPACE: begin
        if (line_in) begin
          state_next    = MARK;
          mark_cnt_next = CNT_ONE;
        end else if (space_cnt_reg != CNT_MAX) begin
          space_cnt_next = space_cnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Letter end is judged on the buffer including any element just added
    if (space_step && (space_cnt_next == LETTER_GAP_C) && (elem_cnt_next != 3'd0)) begin
      if ((elem_cnt_next == 3'd3) && all_dot_next)       code_now = CODE_S;
      else if ((elem_cnt_next == 3'd3) && all_dash_next) code_now = CODE_O;
      else                                               code_now = CODE_OTHER;
      lv_next       = 1'b1;
      code_next     = code_now;
      elem_cnt_next = 3'd0;
      all_dot_next  = 1'b1;
      all_dash_next = 1'b1;
      case (seq_reg)
        SEQ0:    seq_next = (code_now == CODE_S) ? SEQ_S : SEQ0;
        SEQ_S: begin
          if (code_now == CODE_O)      seq_next = SEQ_SO;
          else if (code_now == CODE_S) seq_next = SEQ_S;
          else                         seq_next = SEQ0;
        end
        SEQ_SO: begin
          if (code_now == CODE_S) begin
            sos_next = 1'b1;
            seq_next = SEQ_S;   // the final S may start the next SOS
          end else begin
            seq_next = SEQ0;
          end
        end
        default: seq_next = SEQ0;
      endcase
    end

    // A long silence ends the word: forget the sequence and go idle
    if (space_step && (space_cnt_next == WORD_GAP_C)) begin
      state_next    = IDLE;
      seq_next      = SEQ0;
      elem_cnt_next = 3'd0;
      all_dot_next  = 1'b1;
      all_dash_next = 1'b1;
    end
  end

  assign dotPulse    = dot_reg;
  assign dashPulse   = dash_reg;
  assign errorFlag   = err_reg;
  assign letterValid = lv_reg;
  assign letterCode  = code_reg;
  assign sosDetected = sos_reg;

endmodule

// File: tb/tb_sos_receiver.sv
// tb_sos_receiver: directed-vector bench for sos_receiver (default build).
module tb_sos_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataIn;
  logic       dotPulse;
  logic       dashPulse;
  logic       letterValid;
  logic [1:0] letterCode;
  logic       sosDetected;
  logic       errorFlag;

  sos_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .dataIn     (dataIn),
    .dotPulse   (dotPulse),
    .dashPulse  (dashPulse),
    .letterValid(letterValid),
    .letterCode (letterCode),
    .sosDetected(sosDetected),
    .errorFlag  (errorFlag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int n_dot, n_dash, n_err, n_sos, n_sos_alone;
  int codes[$];
  int exp_q[$];

  // Count one comparison and report it
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic clr_counts();
    n_dot = 0; n_dash = 0; n_err = 0; n_sos = 0; n_sos_alone = 0;
    codes.delete();
  endtask

  // Drive one sample, wait for the edge, then observe the registered outputs
  task automatic tick(input logic v);
    dataIn = v;
    @(posedge clk);
    #1;
    if (dotPulse)    n_dot++;
    if (dashPulse)   n_dash++;
    if (errorFlag)   n_err++;
    if (letterValid) codes.push_back(int'(letterCode));
    if (sosDetected) begin
      n_sos++;
      if (!letterValid) n_sos_alone++;
    end
  endtask

  // n marks of len high cycles separated by gap lows, then a 3-low letter gap
  task automatic send_letter(input int n, input int len, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (len) tick(1'b1);
      if (i < n - 1) repeat (gap) tick(1'b0);
    end
    repeat (3) tick(1'b0);
  endtask

  task automatic send_s(); send_letter(3, 1, 1); endtask
  task automatic send_o(); send_letter(3, 3, 1); endtask

  // Silence long enough to pass the word gap, then clear the tallies
  task automatic flush();
    repeat (10) tick(1'b0);
    clr_counts();
  endtask

  task automatic check_codes(input string tag, input int e[$]);
    check({tag, "_nletters"}, codes.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s_code%0d", tag, i), (i < codes.size()) ? codes[i] : -1, e[i]);
  endtask

  function automatic int outs_word();
    return {26'd0, dotPulse, dashPulse, letterValid, letterCode, sosDetected, errorFlag} & 32'h7F;
  endfunction

  initial begin
    rst = 1'b1;
    dataIn = 1'b0;
    clr_counts();

    // Reset state
    tick(1'b0);
    tick(1'b0);
    check("reset_outputs", outs_word(), 0);
    rst = 1'b0;
    tick(1'b0);
    check("post_reset_outputs", outs_word(), 0);
    flush();

    // SOS with hand-stepped first letter for latency checks
    tick(1'b1);
    check("dot_not_early", int'(dotPulse), 0);
    tick(1'b0);
    check("dot_timing", int'(dotPulse), 1);
    tick(1'b1); tick(1'b0); tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    check("lv_not_early", int'(letterValid), 0);
    tick(1'b0);
    check("lv_timing", int'(letterValid), 1);
    check("lv_code_s", int'(letterCode), 1);
    tick(1'b0);
    check("lv_one_cycle", int'(letterValid), 0);
    check("code_hold", int'(letterCode), 1);
    send_o();
    send_s();
    check("sos_dots", n_dot, 6);
    check("sos_dashes", n_dash, 3);
    exp_q = '{1, 2, 1};
    check_codes("sos", exp_q);
    check("sos_detect", n_sos, 1);
    check("sos_with_lv", n_sos_alone, 0);
    check("sos_no_err", n_err, 0);
    flush();

    // Overlapping S O S O S
    send_s(); send_o(); send_s(); send_o(); send_s();
    exp_q = '{1, 2, 1, 2, 1};
    check_codes("ovl", exp_q);
    check("ovl_detect", n_sos, 2);
    check("ovl_with_lv", n_sos_alone, 0);
    flush();

    // Wrong letter: S O I S
    send_s(); send_o(); send_letter(2, 1, 1); send_s();
    exp_q = '{1, 2, 0, 1};
    check_codes("wrong", exp_q);
    check("wrong_no_sos", n_sos, 0);
    flush();

    // Word gap: S O, 8 lows total, S (no SOS), then O S completes from SEQ_S
    send_s(); send_o(); repeat (5) tick(1'b0);
    send_s();
    check("wgap_no_sos", n_sos, 0);
    send_o(); send_s();
    exp_q = '{1, 2, 1, 2, 1};
    check_codes("wgap", exp_q);
    check("wgap_seq_s", n_sos, 1);
    flush();

    // Long mark: S O, 7-high mark, then S must not complete SOS
    send_s(); send_o();
    repeat (7) tick(1'b1);
    tick(1'b0);
    check("err_timing", int'(errorFlag), 1);
    check("err_no_dash", int'(dashPulse), 0);
    check("err_no_dot", int'(dotPulse), 0);
    repeat (3) tick(1'b0);
    send_s();
    exp_q = '{1, 2, 1};
    check_codes("err", exp_q);
    check("err_count", n_err, 1);
    check("err_seq0", n_sos, 0);
    flush();

    // Boundaries: 2-high dots, 6-high dashes with 2-low spacing, 4-dot letter
    send_letter(3, 2, 1);
    send_letter(3, 6, 2);
    send_letter(4, 1, 1);
    exp_q = '{1, 2, 0};
    check_codes("bnd", exp_q);
    check("bnd_dots", n_dot, 7);
    check("bnd_dashes", n_dash, 3);
    check("bnd_no_err", n_err, 0);
    check("bnd_no_sos", n_sos, 0);
    flush();

    // Reset after 2 dots, held during a mark; then a full S
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
    check("rstmid_pre_dots", n_dot, 2);
    clr_counts();
    rst = 1'b1;
    tick(1'b1);
    check("rstmid_during0", outs_word(), 0);
    tick(1'b1);
    check("rstmid_during1", outs_word(), 0);
    rst = 1'b0;
    tick(1'b1);
    check("rstmid_after", outs_word(), 0);
    tick(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b1);
    repeat (3) tick(1'b0);
    exp_q = '{1};
    check_codes("rstmid", exp_q);
    check("rstmid_dots", n_dot, 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
